// File: rtl/idma_legalizer_resp_joiner_pkg.sv
// Shared types for the legalizer response joiner: AXI response codes, FSM states,
// the joined-response record and the response-merge helper.
package idma_legalizer_resp_joiner_pkg;

  localparam int unsigned BURST_CNT_WIDTH = 12;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef logic [BURST_CNT_WIDTH-1:0] burst_cnt_t;

  typedef struct packed {
    logic [1:0] resp;
    burst_cnt_t err_idx;
  } xfer_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  // The first burst seeds the accumulator; EXOKAY survives only while every burst is EXOKAY.
  function automatic logic [1:0] join_resp(input logic [1:0] acc, input logic [1:0] rsp,
                                           input logic first);
    logic [1:0] res;
    if (first) begin
      res = rsp;
    end else if ((acc == RESP_EXOKAY) && (rsp == RESP_EXOKAY)) begin
      res = RESP_EXOKAY;
    end else begin
      res = RESP_OKAY;
    end
    return res;
  endfunction

endpackage

// File: rtl/idma_legalizer_resp_joiner_if.sv
// Handshake bundle for the response joiner: split announcements, per-burst
// responses in, joined transfer response out.
interface idma_legalizer_resp_joiner_if #(
  parameter int unsigned BurstCntWidth = 12
) ();

  logic                     split_valid_i;
  logic                     split_ready_o;
  logic [BurstCntWidth-1:0] split_num_i;
  logic                     burst_rsp_valid_i;
  logic                     burst_rsp_ready_o;
  logic [1:0]               burst_rsp_i;
  logic                     xfer_rsp_valid_o;
  logic                     xfer_rsp_ready_i;
  logic [1:0]               xfer_rsp_o;
  logic [BurstCntWidth-1:0] xfer_err_idx_o;
  logic                     busy_o;

  modport slave (
    input  split_valid_i, split_num_i, burst_rsp_valid_i, burst_rsp_i, xfer_rsp_ready_i,
    output split_ready_o, burst_rsp_ready_o, xfer_rsp_valid_o, xfer_rsp_o, xfer_err_idx_o,
           busy_o
  );

  modport master (
    output split_valid_i, split_num_i, burst_rsp_valid_i, burst_rsp_i, xfer_rsp_ready_i,
    input  split_ready_o, burst_rsp_ready_o, xfer_rsp_valid_o, xfer_rsp_o, xfer_err_idx_o,
           busy_o
  );

endinterface

// File: rtl/idma_legalizer_resp_joiner_fifo.sv
// Non-fall-through FIFO holding split counts; a pushed entry reaches the head
// one cycle later. Depth must be a power of two.
module idma_legalizer_resp_joiner_fifo #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         i_push,
  input  logic [DataWidth-1:0]         i_data,
  input  logic                         i_pop,
  output logic [DataWidth-1:0]         o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(Depth):0]       o_usage
);

  localparam int unsigned AddrWidth = $clog2(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AddrWidth-1:0] r_wr_ptr;
  logic [AddrWidth-1:0] r_rd_ptr;
  logic [AddrWidth:0]   r_usage;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_usage == (AddrWidth+1)'(Depth));
  assign o_empty = (r_usage == '0);
  assign o_usage = r_usage;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AddrWidth'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AddrWidth'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_usage <= r_usage + (AddrWidth+1)'(1);
        2'b01:   r_usage <= r_usage - (AddrWidth+1)'(1);
        default: r_usage <= r_usage;
      endcase
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/idma_legalizer_resp_joiner.sv
// Joins N per-burst write responses into one transfer response, first error wins.
// Optional saturating error-burst counter on err_cnt_o under IDMA_RESP_JOINER_ERR_CNT_EN.
module idma_legalizer_resp_joiner
  import idma_legalizer_resp_joiner_pkg::*;
#(
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned BurstCntWidth  = BURST_CNT_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  idma_legalizer_resp_joiner_if.slave bus
`ifdef IDMA_RESP_JOINER_ERR_CNT_EN
  ,
  output logic [15:0]                 err_cnt_o
`endif
);

  localparam int unsigned AddrWidth = $clog2(NumOutstanding);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic                     r_burst_ready;
  logic [BurstCntWidth-1:0] r_burst_cnt;
  logic [BurstCntWidth-1:0] r_err_idx;
  logic [1:0]               r_acc;
  logic                     r_err_latched;
  logic                     r_xfer_valid;
  logic [1:0]               r_xfer_rsp;
  logic [BurstCntWidth-1:0] r_xfer_err_idx;

  logic [BurstCntWidth-1:0] w_head_num;
  logic [AddrWidth:0]       w_usage;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_burst_hs;
  logic                     w_last_burst;
  logic                     w_xfer_hs;
  logic                     w_more_after_pop;
  logic [1:0]               w_acc_nxt;
  logic [BurstCntWidth-1:0] w_err_idx_nxt;
  logic                     w_err_latched_nxt;

  idma_legalizer_resp_joiner_fifo #(
    .Depth     (NumOutstanding),
    .DataWidth (BurstCntWidth)
  ) i_cnt_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (bus.split_num_i),
    .i_pop   (w_xfer_hs),
    .o_data  (w_head_num),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_usage (w_usage)
  );

  assign w_push     = bus.split_valid_i && !w_full;
  assign w_burst_hs = bus.burst_rsp_valid_i && r_burst_ready;
  assign w_xfer_hs  = r_xfer_valid && bus.xfer_rsp_ready_i;
  // Equality compare on the pre-increment count, so an all-ones split never overflows.
  assign w_last_burst     = w_burst_hs && (r_burst_cnt == w_head_num);
  assign w_more_after_pop = (w_usage > (AddrWidth+1)'(1)) || w_push;

  // Next-state decode for the IDLE / COLLECT / EMIT sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (w_last_burst) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_EMIT: begin
        if (w_xfer_hs && w_more_after_pop) begin
          w_state_nxt = ST_COLLECT;
        end else if (w_xfer_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus a registered copy of the COLLECT decode used as burst ready.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_burst_ready <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_burst_ready <= (w_state_nxt == ST_COLLECT);
    end
  end

  // Accumulator update for the current burst; frozen once an error is latched.
  always_comb begin
    w_acc_nxt         = r_acc;
    w_err_idx_nxt     = r_err_idx;
    w_err_latched_nxt = r_err_latched;
    if (w_burst_hs && !r_err_latched && bus.burst_rsp_i[1]) begin
      w_acc_nxt         = bus.burst_rsp_i;
      w_err_idx_nxt     = r_burst_cnt;
      w_err_latched_nxt = 1'b1;
    end else if (w_burst_hs && !r_err_latched) begin
      w_acc_nxt         = join_resp(r_acc, bus.burst_rsp_i, (r_burst_cnt == '0));
      w_err_idx_nxt     = r_err_idx;
      w_err_latched_nxt = 1'b0;
    end else begin
      w_acc_nxt         = r_acc;
      w_err_idx_nxt     = r_err_idx;
      w_err_latched_nxt = r_err_latched;
    end
  end

  // Burst counter, accumulator and the held transfer-response output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_burst_cnt    <= '0;
      r_acc          <= RESP_OKAY;
      r_err_idx      <= '0;
      r_err_latched  <= 1'b0;
      r_xfer_valid   <= 1'b0;
      r_xfer_rsp     <= RESP_OKAY;
      r_xfer_err_idx <= '0;
    end else if (w_xfer_hs) begin
      r_burst_cnt    <= '0;
      r_acc          <= RESP_OKAY;
      r_err_idx      <= '0;
      r_err_latched  <= 1'b0;
      r_xfer_valid   <= 1'b0;
      r_xfer_rsp     <= RESP_OKAY;
      r_xfer_err_idx <= '0;
    end else if (w_burst_hs) begin
      r_burst_cnt   <= r_burst_cnt + BurstCntWidth'(1);
      r_acc         <= w_acc_nxt;
      r_err_idx     <= w_err_idx_nxt;
      r_err_latched <= w_err_latched_nxt;
      if (w_last_burst) begin
        r_xfer_valid   <= 1'b1;
        r_xfer_rsp     <= w_acc_nxt;
        r_xfer_err_idx <= w_err_idx_nxt;
      end
    end
  end

`ifdef IDMA_RESP_JOINER_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  // Saturating count of every erroring burst since reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_cnt <= 16'd0;
    end else if (w_burst_hs && bus.burst_rsp_i[1] && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  assign bus.split_ready_o     = !w_full;
  assign bus.burst_rsp_ready_o = r_burst_ready;
  assign bus.xfer_rsp_valid_o  = r_xfer_valid;
  assign bus.xfer_rsp_o        = r_xfer_rsp;
  assign bus.xfer_err_idx_o    = r_xfer_err_idx;
  assign bus.busy_o            = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_idma_legalizer_resp_joiner.sv
// Directed bench for the response joiner: single/multi-burst joins, EXOKAY rules,
// FIFO full, backpressure, max split count and reset mid-transfer.
module tb_idma_legalizer_resp_joiner;
  import idma_legalizer_resp_joiner_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  idma_legalizer_resp_joiner_if #(.BurstCntWidth(12)) bus_if ();

`ifdef IDMA_RESP_JOINER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  idma_legalizer_resp_joiner #(
    .NumOutstanding (4),
    .BurstCntWidth  (12)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
`ifdef IDMA_RESP_JOINER_ERR_CNT_EN
    ,
    .err_cnt_o (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_split(input logic [11:0] num);
    int waited;
    waited = 0;
    bus_if.split_valid_i = 1'b1;
    bus_if.split_num_i   = num;
    while (!bus_if.split_ready_o && waited < 20) begin
      tick();
      waited++;
    end
    n_total++;
    if (bus_if.split_ready_o !== 1'b1) $display("FAIL split_ready_timeout got %b want 1", bus_if.split_ready_o);
    else n_pass++;
    tick();
    bus_if.split_valid_i = 1'b0;
  endtask

  task automatic send_burst(input logic [1:0] rsp);
    int waited;
    waited = 0;
    bus_if.burst_rsp_valid_i = 1'b1;
    bus_if.burst_rsp_i       = rsp;
    while (!bus_if.burst_rsp_ready_o && waited < 20) begin
      tick();
      waited++;
    end
    n_total++;
    if (bus_if.burst_rsp_ready_o !== 1'b1) $display("FAIL burst_ready_timeout got %b want 1", bus_if.burst_rsp_ready_o);
    else n_pass++;
    tick();
    bus_if.burst_rsp_valid_i = 1'b0;
  endtask

  task automatic pop_xfer();
    bus_if.xfer_rsp_ready_i = 1'b1;
    tick();
    bus_if.xfer_rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_total++;
    if ({bus_if.split_ready_o, bus_if.burst_rsp_ready_o, bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o,
         bus_if.xfer_err_idx_o, bus_if.busy_o} !== {1'b1, 1'b0, 1'b0, 2'd0, 12'd0, 1'b0})
      $display("FAIL reset_outputs got rdy=%b brdy=%b v=%b rsp=%0d idx=%0d busy=%b want 1 0 0 0 0 0",
               bus_if.split_ready_o, bus_if.burst_rsp_ready_o, bus_if.xfer_rsp_valid_o,
               bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o, bus_if.busy_o);
    else n_pass++;
  endtask

  task automatic test_single();
    push_split(12'd0);
    tick();
    bus_if.burst_rsp_valid_i = 1'b1;
    bus_if.burst_rsp_i       = RESP_OKAY;
    n_total++;
    if (bus_if.burst_rsp_ready_o !== 1'b1 || bus_if.xfer_rsp_valid_o !== 1'b0)
      $display("FAIL single_pre got brdy=%b v=%b want 1 0", bus_if.burst_rsp_ready_o, bus_if.xfer_rsp_valid_o);
    else n_pass++;
    tick();
    bus_if.burst_rsp_valid_i = 1'b0;
    n_total++;
    if ({bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o, bus_if.burst_rsp_ready_o} !==
        {1'b1, RESP_OKAY, 12'd0, 1'b0})
      $display("FAIL single_rsp got v=%b rsp=%0d idx=%0d brdy=%b want 1 0 0 0", bus_if.xfer_rsp_valid_o,
               bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o, bus_if.burst_rsp_ready_o);
    else n_pass++;
    pop_xfer();
    n_total++;
    if (bus_if.xfer_rsp_valid_o !== 1'b0 || bus_if.busy_o !== 1'b0)
      $display("FAIL single_pop got v=%b busy=%b want 0 0", bus_if.xfer_rsp_valid_o, bus_if.busy_o);
    else n_pass++;
  endtask

  task automatic test_multi_err();
    push_split(12'd3);
    send_burst(RESP_OKAY);
    send_burst(RESP_SLVERR);
    send_burst(RESP_DECERR);
    n_total++;
    if (bus_if.xfer_rsp_valid_o !== 1'b0)
      $display("FAIL multi_early got v=%b want 0", bus_if.xfer_rsp_valid_o);
    else n_pass++;
    send_burst(RESP_OKAY);
    n_total++;
    if ({bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o} !== {1'b1, RESP_SLVERR, 12'd1})
      $display("FAIL multi_err got v=%b rsp=%0d idx=%0d want 1 2 1", bus_if.xfer_rsp_valid_o,
               bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o);
    else n_pass++;
    pop_xfer();
    n_total++;
    if (bus_if.xfer_rsp_valid_o !== 1'b0 || bus_if.busy_o !== 1'b0)
      $display("FAIL multi_pop got v=%b busy=%b want 0 0", bus_if.xfer_rsp_valid_o, bus_if.busy_o);
    else n_pass++;
  endtask

  task automatic test_exokay();
    logic [1:0] first_rsp [3];
    logic [1:0] second_rsp [3];
    logic [1:0] want_rsp [3];
    first_rsp  = '{RESP_EXOKAY, RESP_EXOKAY, RESP_OKAY};
    second_rsp = '{RESP_EXOKAY, RESP_OKAY, RESP_EXOKAY};
    want_rsp   = '{RESP_EXOKAY, RESP_OKAY, RESP_OKAY};
    for (int i = 0; i < 3; i++) begin
      push_split(12'd1);
      send_burst(first_rsp[i]);
      send_burst(second_rsp[i]);
      n_total++;
      if ({bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o} !== {1'b1, want_rsp[i], 12'd0})
        $display("FAIL exokay_%0d got v=%b rsp=%0d idx=%0d want 1 %0d 0", i, bus_if.xfer_rsp_valid_o,
                 bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o, want_rsp[i]);
      else n_pass++;
      pop_xfer();
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0] codes [4];
    codes = '{RESP_OKAY, RESP_EXOKAY, RESP_OKAY, RESP_EXOKAY};
    for (int i = 0; i < 4; i++) push_split(12'd0);
    n_total++;
    if (bus_if.split_ready_o !== 1'b0 || bus_if.busy_o !== 1'b1)
      $display("FAIL full_ready got rdy=%b busy=%b want 0 1", bus_if.split_ready_o, bus_if.busy_o);
    else n_pass++;
    bus_if.split_valid_i = 1'b1;
    bus_if.split_num_i   = 12'd0;
    tick();
    tick();
    tick();
    send_burst(codes[0]);
    n_total++;
    if (bus_if.xfer_rsp_valid_o !== 1'b1 || bus_if.split_ready_o !== 1'b0)
      $display("FAIL full_emit got v=%b rdy=%b want 1 0", bus_if.xfer_rsp_valid_o, bus_if.split_ready_o);
    else n_pass++;
    pop_xfer();
    n_total++;
    if (bus_if.split_ready_o !== 1'b1)
      $display("FAIL full_after_pop got rdy=%b want 1", bus_if.split_ready_o);
    else n_pass++;
    tick();
    bus_if.split_valid_i = 1'b0;
    n_total++;
    if (bus_if.split_ready_o !== 1'b0)
      $display("FAIL full_refill got rdy=%b want 0", bus_if.split_ready_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      send_burst(codes[i]);
      n_total++;
      if ({bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o} !== {1'b1, codes[i]})
        $display("FAIL full_drain_%0d got v=%b rsp=%0d want 1 %0d", i, bus_if.xfer_rsp_valid_o,
                 bus_if.xfer_rsp_o, codes[i]);
      else n_pass++;
      pop_xfer();
    end
    n_total++;
    if (bus_if.busy_o !== 1'b0)
      $display("FAIL full_idle got busy=%b want 0", bus_if.busy_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    push_split(12'd0);
    push_split(12'd1);
    send_burst(RESP_OKAY);
    bus_if.burst_rsp_valid_i = 1'b1;
    bus_if.burst_rsp_i       = RESP_SLVERR;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if ({bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o, bus_if.burst_rsp_ready_o} !==
          {1'b1, RESP_OKAY, 12'd0, 1'b0})
        $display("FAIL bp_hold_%0d got v=%b rsp=%0d idx=%0d brdy=%b want 1 0 0 0", i,
                 bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o, bus_if.burst_rsp_ready_o);
      else n_pass++;
      tick();
    end
    bus_if.burst_rsp_valid_i = 1'b0;
    pop_xfer();
    n_total++;
    if (bus_if.burst_rsp_ready_o !== 1'b1 || bus_if.xfer_rsp_valid_o !== 1'b0)
      $display("FAIL bp_next_start got brdy=%b v=%b want 1 0", bus_if.burst_rsp_ready_o, bus_if.xfer_rsp_valid_o);
    else n_pass++;
    send_burst(RESP_SLVERR);
    send_burst(RESP_OKAY);
    n_total++;
    if ({bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o} !== {1'b1, RESP_SLVERR, 12'd0})
      $display("FAIL bp_second got v=%b rsp=%0d idx=%0d want 1 2 0", bus_if.xfer_rsp_valid_o,
               bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o);
    else n_pass++;
    pop_xfer();
  endtask

  task automatic test_max_split();
    int fails_before;
    fails_before = n_total - n_pass;
    push_split(12'hFFF);
    for (int i = 0; i < 4095; i++) begin
      send_burst(RESP_OKAY);
      if ((n_total - n_pass) != fails_before) break;
    end
    n_total++;
    if (bus_if.xfer_rsp_valid_o !== 1'b0)
      $display("FAIL max_early got v=%b want 0", bus_if.xfer_rsp_valid_o);
    else n_pass++;
    send_burst(RESP_DECERR);
    n_total++;
    if ({bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o} !== {1'b1, RESP_DECERR, 12'hFFF})
      $display("FAIL max_last got v=%b rsp=%0d idx=%0d want 1 3 4095", bus_if.xfer_rsp_valid_o,
               bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o);
    else n_pass++;
    pop_xfer();
  endtask

  task automatic test_reset_mid();
    push_split(12'd3);
    send_burst(RESP_OKAY);
    send_burst(RESP_OKAY);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_total++;
    if ({bus_if.busy_o, bus_if.split_ready_o, bus_if.burst_rsp_ready_o, bus_if.xfer_rsp_valid_o} !==
        {1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL rst_mid got busy=%b rdy=%b brdy=%b v=%b want 0 1 0 0", bus_if.busy_o,
               bus_if.split_ready_o, bus_if.burst_rsp_ready_o, bus_if.xfer_rsp_valid_o);
    else n_pass++;
    bus_if.burst_rsp_valid_i = 1'b1;
    bus_if.burst_rsp_i       = RESP_SLVERR;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if ({bus_if.burst_rsp_ready_o, bus_if.xfer_rsp_valid_o, bus_if.busy_o} !== 3'b000)
      $display("FAIL rst_empty_wait got brdy=%b v=%b busy=%b want 0 0 0", bus_if.burst_rsp_ready_o,
               bus_if.xfer_rsp_valid_o, bus_if.busy_o);
    else n_pass++;
    bus_if.burst_rsp_valid_i = 1'b0;
    push_split(12'd0);
    send_burst(RESP_DECERR);
    n_total++;
    if ({bus_if.xfer_rsp_valid_o, bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o} !== {1'b1, RESP_DECERR, 12'd0})
      $display("FAIL rst_fresh got v=%b rsp=%0d idx=%0d want 1 3 0", bus_if.xfer_rsp_valid_o,
               bus_if.xfer_rsp_o, bus_if.xfer_err_idx_o);
    else n_pass++;
    pop_xfer();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus_if.split_valid_i     = 1'b0;
    bus_if.split_num_i       = 12'd0;
    bus_if.burst_rsp_valid_i = 1'b0;
    bus_if.burst_rsp_i       = 2'd0;
    bus_if.xfer_rsp_ready_i  = 1'b0;
    test_reset();
    test_single();
    test_multi_err();
    test_exokay();
    test_fifo_full();
    test_backpressure();
    test_max_split();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
